// File: rtl/alu_operand_loader.sv
// alu_operand_loader: gathers one command plus 2*BEATS operand words into op1/op2 for an ALU.
// Latency: 1 + 2*BEATS cycles from command transfer to issue_valid with words streaming back to back.
// Backpressure: cmd_ready / word_ready / issue_valid are pure state decodes; ISSUE holds until issue_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake carrying cmd_opsel, cmd_mode
//   word_valid/word_ready    operand word handshake carrying word_data, word_par (even parity)
//   op1, op2, opsel, mode    operand set to the ALU, valid while issue_valid is high
//   issue_valid/issue_ready  operand set handshake
//   err                      sticky parity error, cleared by the next accepted command
//
// Build option: define LOADER_PARITY_EN to check word parity and abort the command on a bad word.
// Without it word_par is ignored and err is constant 0.

module alu_operand_loader #(
  parameter int DWIDTH = 128,
  parameter int WWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_opsel,
  input  logic              cmd_mode,
  output logic              cmd_ready,
  input  logic              word_valid,
  input  logic [WWIDTH-1:0] word_data,
  input  logic              word_par,
  output logic              word_ready,
  output logic [DWIDTH-1:0] op1,
  output logic [DWIDTH-1:0] op2,
  output logic [2:0]        opsel,
  output logic              mode,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic              err
);

  localparam int BEATS = DWIDTH / WWIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_OP1 = 2'd1,
    LOAD_OP2 = 2'd2,
    ISSUE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] op1_q, op1_d;
  logic [DWIDTH-1:0] op2_q, op2_d;
  logic [2:0]        opsel_q, opsel_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic              par_bad;

`ifdef LOADER_PARITY_EN
  // Even parity: data bits plus the parity bit must XOR to zero.
  assign par_bad = ^{word_data, word_par};
`else
  logic unused_word_par;
  assign unused_word_par = word_par;
  assign par_bad         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      opsel_q <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opsel_q <= opsel_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opsel_d = opsel_q;
    mode_d  = mode_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          opsel_d = cmd_opsel;
          mode_d  = cmd_mode;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = LOAD_OP1;
        end
      end

      LOAD_OP1, LOAD_OP2: begin
        if (word_valid) begin
          if (par_bad) begin
            // Bad word is dropped and the whole command is abandoned.
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            // Least-significant word arrives first.
            if (state_q == LOAD_OP1) begin
              op1_d[int'(cnt_q)*WWIDTH +: WWIDTH] = word_data;
            end else begin
              op2_d[int'(cnt_q)*WWIDTH +: WWIDTH] = word_data;
            end
            if (cnt_q == LAST_BEAT) begin
              cnt_d   = '0;
              state_d = (state_q == LOAD_OP1) ? LOAD_OP2 : ISSUE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end

      ISSUE: begin
        if (issue_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only.
  assign cmd_ready   = (state_q == IDLE);
  assign word_ready  = (state_q == LOAD_OP1) || (state_q == LOAD_OP2);
  assign issue_valid = (state_q == ISSUE);
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign opsel       = opsel_q;
  assign mode        = mode_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: self-checking bench for alu_operand_loader at default parameters.
// Stimulus is randomized; expected operands, latency and handshake behaviour come from a
// word-list model (operand = words concatenated LS word first, latency = 1 + words + idle gaps).

module tb_alu_operand_loader;

  typedef logic [31:0] words_t [8];

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [2:0]   cmd_opsel;
  logic         cmd_mode;
  logic         cmd_ready;
  logic         word_valid;
  logic [31:0]  word_data;
  logic         word_par;
  logic         word_ready;
  logic [127:0] op1;
  logic [127:0] op2;
  logic [2:0]   opsel;
  logic         mode;
  logic         issue_valid;
  logic         issue_ready;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_operand_loader #(.DWIDTH(128), .WWIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_opsel   (cmd_opsel),
    .cmd_mode    (cmd_mode),
    .cmd_ready   (cmd_ready),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_par    (word_par),
    .word_ready  (word_ready),
    .op1         (op1),
    .op2         (op2),
    .opsel       (opsel),
    .mode        (mode),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Reference model: an operand is its four words concatenated, word 0 least significant.
  function automatic logic [127:0] pack_op(input words_t w, input int base);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = w[base + k];
    return r;
  endfunction

  function automatic void rand_words(output words_t w);
    for (int k = 0; k < 8; k++) w[k] = $urandom;
  endfunction

  // Drives one command and its eight words, then holds ISSUE for 'stall' edges before the
  // handshake. Reports what it observed; callers do the comparisons.
  // gap: 0 = word_valid always high, 1 = low/high toggle starting low, 2 = random gaps.
  task automatic run_cmd(
    input  logic [2:0]   os,
    input  logic         m,
    input  words_t       w,
    input  int           gap,
    input  int           stall,
    input  int           bad_idx,
    output int           lat,
    output int           exp_lat,
    output bit           aborted,
    output bit           timeout,
    output int           hold_bad,
    output logic [127:0] o1,
    output logic [127:0] o2,
    output logic [2:0]   so,
    output logic         sm,
    output logic         idle_after,
    output logic         err_after_cmd
  );
    int idx, lows, waitc;
    bit ph, wv, rdy_now;
    lat = 0; exp_lat = 0; aborted = 0; timeout = 0; hold_bad = 0;
    o1 = '0; o2 = '0; so = '0; sm = 1'b0; idle_after = 1'b0; err_after_cmd = 1'b1;
    @(negedge clk);
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (cmd_ready !== 1'b1) begin
      timeout = 1;
      return;
    end
    cmd_valid = 1'b1; cmd_opsel = os; cmd_mode = m; issue_ready = 1'b0;
    word_valid = 1'b1; word_data = $urandom; word_par = 1'($urandom);  // offered in IDLE: ignored
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    err_after_cmd = err;
    idx = 0; lows = 0; ph = 0;
    while (1'b1) begin
      if (issue_valid === 1'b1) break;
      if (cmd_ready === 1'b1) begin
        aborted = 1;
        break;
      end
      if (lat > 200) begin
        timeout = 1;
        break;
      end
      case (gap)
        0:       wv = 1'b1;
        1:       begin wv = ph; ph = ~ph; end
        default: wv = ($urandom_range(0, 2) != 0);
      endcase
      if (idx >= 8) wv = 1'b0;
      // Commands during a load must be ignored.
      cmd_valid = 1'($urandom_range(0, 1)); cmd_opsel = 3'($urandom); cmd_mode = 1'($urandom);
      if (wv) begin
        word_valid = 1'b1;
        word_data  = w[idx];
        word_par   = (^w[idx]) ^ (idx == bad_idx);
      end else begin
        word_valid = 1'b0;
        word_data  = $urandom;
        word_par   = 1'($urandom);
        lows++;
      end
      rdy_now = word_ready;
      @(posedge clk);
      lat++;
      if (wv && rdy_now) idx++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    word_valid = 1'b0;
    exp_lat = 1 + 8 + lows;
    if (timeout || aborted) return;
    o1 = op1; o2 = op2; so = opsel; sm = mode;
    for (int s = 0; s < stall; s++) begin
      word_valid = 1'b1; word_data = $urandom; word_par = 1'($urandom);
      cmd_valid = 1'b1; cmd_opsel = 3'($urandom); cmd_mode = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (issue_valid !== 1'b1 || op1 !== o1 || op2 !== o2 || opsel !== so || mode !== sm ||
          cmd_ready !== 1'b0 || word_ready !== 1'b0) hold_bad++;
    end
    cmd_valid = 1'b0; word_valid = 1'b0; issue_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle_after = cmd_ready & ~issue_valid;
    issue_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL reset_word_ready: got %b expected 0", word_ready); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
    n_checks++; if (op1 !== 128'h0 || op2 !== 128'h0) begin n_fail++; $display("FAIL reset_ops: got %h %h expected 0", op1, op2); end
    n_checks++; if (opsel !== 3'd0 || mode !== 1'b0) begin n_fail++; $display("FAIL reset_opsel_mode: got %0d %b expected 0 0", opsel, mode); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got cmd_ready=%b issue_valid=%b expected 1 0", cmd_ready, issue_valid); end
  endtask

  task automatic test_basic();
    words_t w;
    int lat, el, hb;
    bit ab, to;
    logic [127:0] o1, o2;
    logic [2:0] so;
    logic sm, ia, ea;
    w = '{32'h1, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_cmd(3'b010, 1'b1, w, 0, 0, -1, lat, el, ab, to, hb, o1, o2, so, sm, ia, ea);
    n_checks++; if (to || ab) begin n_fail++; $display("FAIL basic_complete: got timeout=%b aborted=%b expected 0 0", to, ab); end
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL basic_latency: got %0d expected 9", lat); end
    n_checks++; if (o1 !== 128'h1) begin n_fail++; $display("FAIL basic_op1: got %h expected 1", o1); end
    n_checks++; if (o2 !== {128{1'b1}}) begin n_fail++; $display("FAIL basic_op2: got %h expected all ones", o2); end
    n_checks++; if (so !== 3'd2 || sm !== 1'b1) begin n_fail++; $display("FAIL basic_opsel_mode: got %0d %b expected 2 1", so, sm); end
    n_checks++; if (ia !== 1'b1) begin n_fail++; $display("FAIL basic_idle_after: got %b expected 1", ia); end
  endtask

  task automatic test_hold();
    words_t w;
    int lat, el, hb;
    bit ab, to;
    logic [127:0] o1, o2;
    logic [2:0] so;
    logic sm, ia, ea;
    w = '{32'h1, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_cmd(3'b010, 1'b1, w, 0, 5, -1, lat, el, ab, to, hb, o1, o2, so, sm, ia, ea);
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL hold_latency: got %0d expected 9", lat); end
    n_checks++; if (hb != 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", hb); end
    n_checks++; if (o1 !== pack_op(w, 0) || o2 !== pack_op(w, 4)) begin n_fail++; $display("FAIL hold_ops: got %h %h expected %h %h", o1, o2, pack_op(w, 0), pack_op(w, 4)); end
    n_checks++; if (ia !== 1'b1) begin n_fail++; $display("FAIL hold_idle_after: got %b expected 1", ia); end
  endtask

  task automatic test_gaps();
    words_t w;
    int lat, el, hb;
    bit ab, to;
    logic [127:0] o1, o2;
    logic [2:0] so;
    logic sm, ia, ea;
    logic [2:0] os;
    os = 3'($urandom);
    rand_words(w);
    run_cmd(os, 1'b0, w, 1, 0, -1, lat, el, ab, to, hb, o1, o2, so, sm, ia, ea);
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL gaps_latency: got %0d expected 17", lat); end
    n_checks++; if (o1 !== pack_op(w, 0)) begin n_fail++; $display("FAIL gaps_op1: got %h expected %h", o1, pack_op(w, 0)); end
    n_checks++; if (o2 !== pack_op(w, 4)) begin n_fail++; $display("FAIL gaps_op2: got %h expected %h", o2, pack_op(w, 4)); end
    n_checks++; if (so !== os || sm !== 1'b0) begin n_fail++; $display("FAIL gaps_opsel_mode: got %0d %b expected %0d 0", so, sm, os); end
  endtask

  task automatic test_async_reset();
    words_t w;
    int lat, el, hb, stray;
    bit ab, to;
    logic [127:0] o1, o2;
    logic [2:0] so;
    logic sm, ia, ea;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opsel = 3'd5; cmd_mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      word_valid = 1'b1; word_data = $urandom | 32'h1; word_par = ^word_data;
      @(posedge clk);
      @(negedge clk);
    end
    word_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (op1 !== 128'h0 || op2 !== 128'h0) begin n_fail++; $display("FAIL arst_ops: got %h %h expected 0", op1, op2); end
    n_checks++; if (opsel !== 3'd0 || mode !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL arst_regs: got %0d %b %b expected 0 0 0", opsel, mode, err); end
    n_checks++; if (cmd_ready !== 1'b1 || word_ready !== 1'b0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL arst_handshake: got %b %b %b expected 1 0 0", cmd_ready, word_ready, issue_valid); end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      word_valid = 1'b1; word_data = $urandom; word_par = ^word_data;
      @(posedge clk);
      @(negedge clk);
      if (issue_valid !== 1'b0 || word_ready !== 1'b0) stray++;
    end
    word_valid = 1'b0;
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL arst_no_issue: got %0d bad cycles expected 0", stray); end
    rand_words(w);
    run_cmd(3'd6, 1'b0, w, 0, 1, -1, lat, el, ab, to, hb, o1, o2, so, sm, ia, ea);
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL arst_new_latency: got %0d expected 9", lat); end
    n_checks++; if (o1 !== pack_op(w, 0) || o2 !== pack_op(w, 4)) begin n_fail++; $display("FAIL arst_new_ops: got %h %h expected %h %h", o1, o2, pack_op(w, 0), pack_op(w, 4)); end
    n_checks++; if (so !== 3'd6 || sm !== 1'b0) begin n_fail++; $display("FAIL arst_new_opsel: got %0d %b expected 6 0", so, sm); end
  endtask

  task automatic test_parity();
    words_t w;
    int lat, el, hb, stray;
    bit ab, to;
    logic [127:0] o1, o2;
    logic [2:0] so;
    logic sm, ia, ea;
    rand_words(w);
    w[2] = 32'h00000003;  // sent with par=1: odd overall
    run_cmd(3'd1, 1'b1, w, 0, 0, 2, lat, el, ab, to, hb, o1, o2, so, sm, ia, ea);
`ifdef LOADER_PARITY_EN
    n_checks++; if (ab !== 1'b1) begin n_fail++; $display("FAIL par_abort: got aborted=%b expected 1", ab); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL par_err_set: got %b expected 1", err); end
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (issue_valid !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b1) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL par_idle_hold: got %0d bad cycles expected 0", stray); end
    rand_words(w);
    run_cmd(3'd4, 1'b0, w, 0, 0, -1, lat, el, ab, to, hb, o1, o2, so, sm, ia, ea);
    n_checks++; if (ea !== 1'b0) begin n_fail++; $display("FAIL par_err_clear: got %b expected 0", ea); end
    n_checks++; if (lat != 9 || o1 !== pack_op(w, 0)) begin n_fail++; $display("FAIL par_recover: got lat=%0d op1=%h expected 9 %h", lat, o1, pack_op(w, 0)); end
`else
    n_checks++; if (ab !== 1'b0 || lat != 9) begin n_fail++; $display("FAIL nopar_complete: got aborted=%b lat=%0d expected 0 9", ab, lat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL nopar_err: got %b expected 0", err); end
    n_checks++; if (o1 !== pack_op(w, 0) || o2 !== pack_op(w, 4)) begin n_fail++; $display("FAIL nopar_ops: got %h %h expected %h %h", o1, o2, pack_op(w, 0), pack_op(w, 4)); end
`endif
  endtask

  task automatic test_random();
    words_t w;
    int lat, el, hb;
    bit ab, to;
    logic [127:0] o1, o2;
    logic [2:0] so, os;
    logic sm, ia, ea, m;
    for (int it = 0; it < 25; it++) begin
      rand_words(w);
      os = 3'($urandom);
      m  = 1'($urandom);
      run_cmd(os, m, w, 2 * $urandom_range(0, 1), $urandom_range(0, 3), -1,
              lat, el, ab, to, hb, o1, o2, so, sm, ia, ea);
      n_checks++; if (to || ab || lat != el) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d (to=%b ab=%b) expected %0d", it, lat, to, ab, el); end
      n_checks++; if (o1 !== pack_op(w, 0) || o2 !== pack_op(w, 4)) begin n_fail++; $display("FAIL rand_ops[%0d]: got %h %h expected %h %h", it, o1, o2, pack_op(w, 0), pack_op(w, 4)); end
      n_checks++; if (so !== os || sm !== m || hb != 0 || ia !== 1'b1) begin n_fail++; $display("FAIL rand_ctrl[%0d]: got %0d %b hold_bad=%0d idle=%b expected %0d %b 0 1", it, so, sm, hb, ia, os, m); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_opsel = 3'd0; cmd_mode = 1'b0;
    word_valid = 1'b0; word_data = '0; word_par = 1'b0;
    issue_ready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_gaps();
    test_async_reset();
    test_parity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
